// File: rtl/video_source_sequencer_if.sv
// Sync-pulse inputs, mode-request handshake and source-select status bundle
// between the SCART front end (master) and the source sequencer (slave).
interface video_source_sequencer_if;
  logic       hsync;
  logic       vsync;
  logic       isFieldOdd;
  logic [1:0] modeReq;
  logic       modeReqValid;
  logic       modeReqAck;
  logic [1:0] activeMode;
  logic [1:0] sourceSelect;
  logic       keyEnable;
  logic       locked;
  logic       switchPending;
  logic [9:0] lineCount;

  modport master (
    output hsync, vsync, isFieldOdd, modeReq, modeReqValid,
    input  modeReqAck, activeMode, sourceSelect, keyEnable, locked,
           switchPending, lineCount
  );

  modport slave (
    input  hsync, vsync, isFieldOdd, modeReq, modeReqValid,
    output modeReqAck, activeMode, sourceSelect, keyEnable, locked,
           switchPending, lineCount
  );
endinterface

// File: rtl/video_source_sequencer.sv
// Field-synchronous source selector for the SCART output path. Judges AIV sync
// lock from the regenerated hsync/vsync pulses, applies requested modes at
// odd-field boundaries and forces the fallback source while unlocked.
module video_source_sequencer #(
  parameter int unsigned LINES_MIN     = 310,
  parameter int unsigned LINES_MAX     = 315,
  parameter int unsigned LOCK_FIELDS   = 4,
  parameter int unsigned HSYNC_TIMEOUT = 8191,
  parameter logic [1:0]  DEFAULT_MODE  = 2'd0,
  parameter logic [1:0]  FALLBACK_MODE = 2'd1
) (
  input logic                     sysClock,
  input logic                     nReset,
  video_source_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  localparam int TO_W = $clog2(HSYNC_TIMEOUT + 1);
  localparam int GF_W = $clog2(LOCK_FIELDS + 1);
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(HSYNC_TIMEOUT);
  localparam logic [TO_W-1:0] TO_TRIP  = TO_W'(HSYNC_TIMEOUT - 1);
  localparam logic [GF_W-1:0] GF_LOCK  = GF_W'(LOCK_FIELDS);
  localparam logic [10:0]     LMIN     = 11'(LINES_MIN);
  localparam logic [10:0]     LMAX     = 11'(LINES_MAX);
  localparam logic [9:0]      LINE_SAT = 10'h3FF;

  state_t          state_q, state_d;
  logic [GF_W-1:0] gf_q, gf_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [9:0]      line_q, line_d;
  logic            locked_q, locked_d;
  logic [1:0]      active_q, active_d;
  logic [1:0]      sel_q, sel_d;
  logic            key_q, key_d;
  logic            pend_q, pend_d;
  logic [1:0]      pmode_q, pmode_d;
  logic            ack_q, ack_d;

  logic [10:0]     field_lines;
  logic            field_ok;
  logic            timeout;
  logic [GF_W-1:0] gf_inc;
  logic            accept;
  logic            apply;

  // A coincident hsync still belongs to the field that the vsync closes.
  assign field_lines = {1'b0, line_q} + {10'd0, bus.hsync};
  assign field_ok    = (field_lines >= LMIN) && (field_lines <= LMAX);
  // Fires on the cycle the idle counter reaches the limit and keeps firing while held there.
  assign timeout     = !bus.hsync && (to_q >= TO_TRIP);
  assign gf_inc      = gf_q + GF_W'(1);
  assign accept      = bus.modeReqValid && !pend_q;
  assign apply       = pend_q && ((state_q == ST_LOCKED) ? (bus.vsync && bus.isFieldOdd) : 1'b1);

  // State and datapath registers, all returned to power-on values by nReset.
  always_ff @(posedge sysClock or negedge nReset) begin
    if (!nReset) begin
      state_q  <= ST_UNLOCKED;
      gf_q     <= '0;
      to_q     <= '0;
      line_q   <= '0;
      locked_q <= 1'b0;
      active_q <= DEFAULT_MODE;
      sel_q    <= FALLBACK_MODE;
      key_q    <= (FALLBACK_MODE == 2'd2);
      pend_q   <= 1'b0;
      pmode_q  <= DEFAULT_MODE;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gf_q     <= gf_d;
      to_q     <= to_d;
      line_q   <= line_d;
      locked_q <= locked_d;
      active_q <= active_d;
      sel_q    <= sel_d;
      key_q    <= key_d;
      pend_q   <= pend_d;
      pmode_q  <= pmode_d;
      ack_q    <= ack_d;
    end
  end

  // Lock FSM: field judgement on vsync, with the hsync timeout overriding it.
  always_comb begin
    state_d = state_q;
    gf_d    = gf_q;
    if (timeout) begin
      state_d = ST_UNLOCKED;
      gf_d    = '0;
    end else if (bus.vsync) begin
      case (state_q)
        ST_UNLOCKED: begin
          state_d = ST_ACQUIRE;
          gf_d    = '0;
        end
        ST_ACQUIRE: begin
          if (field_ok) begin
            gf_d = gf_inc;
            if (gf_inc >= GF_LOCK) state_d = ST_LOCKED;
          end else begin
            gf_d = '0;
          end
        end
        ST_LOCKED: begin
          if (!field_ok) begin
            state_d = ST_ACQUIRE;
            gf_d    = '0;
          end
        end
        default: begin
          state_d = ST_UNLOCKED;
          gf_d    = '0;
        end
      endcase
    end
  end

  // Outputs and counters derived from the next state so select tracks lock on the same edge.
  always_comb begin
    locked_d = (state_d == ST_LOCKED);
    if (bus.hsync)    to_d = '0;
    else if (timeout) to_d = TO_MAX;
    else              to_d = to_q + TO_W'(1);
    if (timeout || bus.vsync)                line_d = '0;
    else if (bus.hsync && line_q != LINE_SAT) line_d = line_q + 10'd1;
    else                                      line_d = line_q;
    active_d = apply ? pmode_q : active_q;
    pmode_d  = accept ? bus.modeReq : pmode_q;
    if (accept)     pend_d = 1'b1;
    else if (apply) pend_d = 1'b0;
    else            pend_d = pend_q;
    ack_d    = accept;
    sel_d    = locked_d ? active_d : FALLBACK_MODE;
    key_d    = (sel_d == 2'd2);
  end

  assign bus.modeReqAck    = ack_q;
  assign bus.activeMode    = active_q;
  assign bus.sourceSelect  = sel_q;
  assign bus.keyEnable     = key_q;
  assign bus.locked        = locked_q;
  assign bus.switchPending = pend_q;
  assign bus.lineCount     = line_q;
endmodule

// File: doc/video_source_sequencer.md
Name: video_source_sequencer

Overview:
- Field-synchronous controller for the SCART output datapath.
- Decides which video source drives the RGB666/csync outputs: AIV pass-through, Pi DPI, keyed overlay or black.
- Judges AIV sync lock from the regenerated hsync/vsync pulses and applies mode changes only at odd-field boundaries.
- Forces a safe fallback source whenever AIV sync is not locked.

Parameters:
- LINES_MIN, 310, minimum hsync count per field for a valid field
- LINES_MAX, 315, maximum hsync count per field for a valid field
- LOCK_FIELDS, 4, consecutive valid fields required to declare lock
- HSYNC_TIMEOUT, 8191, sysClock cycles without an hsync before lock is lost
- DEFAULT_MODE, 2'd0, activeMode value after reset
- FALLBACK_MODE, 2'd1, sourceSelect value while unlocked

Ports:
- sysClock  in  1  pixel clock x6 domain; all logic is synchronous to it
- nReset  in  1  asynchronous, active-low reset
- hsync  in  1  one-cycle pulse per line from the sync regenerator
- vsync  in  1  one-cycle pulse per field
- isFieldOdd  in  1  field parity, valid when vsync=1
- modeReq  in  2  requested mode: 0 AIV, 1 Pi, 2 overlay keyed, 3 black
- modeReqValid  in  1  requester holds this high until it sees modeReqAck
- modeReqAck  out  1  one-cycle pulse when a request is accepted
- activeMode  out  2  programmed mode
- sourceSelect  out  2  effective mux select: activeMode if locked, else FALLBACK_MODE
- keyEnable  out  1  high when sourceSelect==2
- locked  out  1  AIV sync lock status
- switchPending  out  1  a request has been accepted but not yet applied
- lineCount  out  10  hsyncs counted so far in the current field; saturates at 1023

Behaviour:
- Reset values (async on nReset low): state UNLOCKED, locked=0, activeMode=DEFAULT_MODE, sourceSelect=FALLBACK_MODE, keyEnable=(FALLBACK_MODE==2), switchPending=0, modeReqAck=0, lineCount=0, goodFields=0, timeout counter=0.
- Line counting:
  - Each hsync increments lineCount.
  - On vsync, the field length is fieldLines = lineCount plus 1 if hsync is coincident, else lineCount.
  - lineCount is cleared on the cycle after vsync.
- Field check on vsync: a field is valid when LINES_MIN <= fieldLines <= LINES_MAX.
- States and transitions:
  - UNLOCKED: on the first vsync, clear goodFields and go to ACQUIRE. That first field is not judged.
  - ACQUIRE: a valid field increments goodFields. An invalid field clears goodFields and stays in ACQUIRE. When goodFields reaches LOCK_FIELDS, go to LOCKED and set locked=1 in the same register update.
  - LOCKED: an invalid field clears locked and goodFields and goes to ACQUIRE.
- Timeout:
  - The counter clears on hsync and increments otherwise.
  - Reaching HSYNC_TIMEOUT in any state goes to UNLOCKED, clears locked, goodFields and lineCount, and holds the counter at HSYNC_TIMEOUT until the next hsync.
  - Timeout takes priority over a coincident vsync evaluation.
- Request handshake:
  - A request is accepted when modeReqValid=1 and switchPending=0.
  - Acceptance captures modeReq into the pending register, sets switchPending, and pulses modeReqAck for exactly one cycle.
  - While switchPending=1, no ack is issued; the requester keeps waiting.
- Applying a pending request:
  - When LOCKED, it applies on a vsync with isFieldOdd=1. activeMode updates and switchPending clears on that same clock edge, so sourceSelect changes at the start of the odd field.
  - When not LOCKED, it applies on the cycle after acceptance. sourceSelect stays FALLBACK_MODE.
  - A request accepted on a vsync cycle is not applied by that vsync; it waits for the next qualifying vsync.
- Outputs:
  - sourceSelect and keyEnable are registered: sourceSelect = locked_next ? activeMode_next : FALLBACK_MODE.
  - On entering LOCKED, sourceSelect switches to activeMode on the same edge that locked rises.
- A mode request of the same value as activeMode is still acked and still sets switchPending; it has no visible effect when applied.
- Reset mid-operation discards the pending request. modeReqAck is not issued for a request whose valid is still high until one cycle after nReset deasserts.

Test Plan:
- Lock acquisition: after reset, send 5 vsyncs spaced by 312 hsyncs (the first one starts acquisition) -> locked rises on the 5th vsync; sourceSelect goes 1 -> 0 on that edge.
- Mode switch: while locked, assert modeReq=2 with valid mid even field -> modeReqAck is high for 1 cycle and switchPending=1. The even-field vsync causes no change. At the next odd vsync, activeMode=sourceSelect=2, keyEnable=1, switchPending=0.
- Back-pressure: with switchPending=1, hold modeReqValid with modeReq=3 -> no ack until the pending switch applies. It is acked the cycle after the apply and applies at the following odd vsync.
- Bad field: while locked, send a field of 300 lines -> locked=0 and sourceSelect=1 after that vsync. Then 4 valid fields -> relock with sourceSelect=activeMode.
- Timeout: while locked, stop hsync for 8191 cycles -> locked=0, lineCount=0, sourceSelect=1. Also cover a vsync coincident with the timeout cycle: no lock gain.
- Async reset: assert nReset mid field with a switch pending -> all outputs take their reset values immediately with no clock edge; the pending request is discarded.
